// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver (8E1 when UART_RX_PARITY_EN is defined).
// Recovers LSB-first bytes from an asynchronous serial line and hands them
// to downstream logic through a single valid/ready holding register.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   rx          asynchronous serial input, idle high
//   data        received byte, stable while data_valid=1
//   data_valid  holding register full
//   data_ready  consumer accepts the byte when data_valid & data_ready
//   frame_err   one-cycle pulse: stop bit sampled low
//   overrun     one-cycle pulse: byte completed while holding register full
//   parity_err  one-cycle pulse: even-parity mismatch (0 without the macro)
//
// Optional feature macro: UART_RX_PARITY_EN (adds an even-parity bit).
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned CNT_W        = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd3;
`endif
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [2:0] ST_BREAK  = 3'd5;

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

    logic             rx_q1;
    logic             rx_s;
    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [2:0]       idx;
    logic [2:0]       idx_nxt;
    logic [7:0]       shift;
    logic [7:0]       shift_nxt;
    logic             byte_done;
    logic             byte_done_nxt;
    logic             frame_err_nxt;
`ifdef UART_RX_PARITY_EN
    logic             parity_bad;
    logic             parity_bad_nxt;
    logic             parity_err_nxt;
`endif

    // Next-state and bit-timing logic.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        idx_nxt       = idx;
        shift_nxt     = shift;
        byte_done_nxt = 1'b0;
        frame_err_nxt = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_bad_nxt = parity_bad;
        parity_err_nxt = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                idx_nxt = '0;
`ifdef UART_RX_PARITY_EN
                parity_bad_nxt = 1'b0;
`endif
                if (!rx_s) begin
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                // Re-check the line at mid start bit to reject glitches.
                if (cnt == CNT_HALF) begin
                    cnt_nxt   = '0;
                    state_nxt = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (cnt == CNT_FULL) begin
                    cnt_nxt        = '0;
                    shift_nxt[idx] = rx_s;
                    if (idx == 3'd7) begin
                        idx_nxt = '0;
`ifdef UART_RX_PARITY_EN
                        state_nxt = ST_PARITY;
`else
                        state_nxt = ST_STOP;
`endif
                    end else begin
                        idx_nxt = idx + 3'd1;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt == CNT_FULL) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_STOP;
                    if ((^shift) != rx_s) begin
                        parity_err_nxt = 1'b1;
                        parity_bad_nxt = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
`endif
            ST_STOP: begin
                if (cnt == CNT_FULL) begin
                    cnt_nxt = '0;
                    if (rx_s) begin
                        state_nxt = ST_IDLE;
`ifdef UART_RX_PARITY_EN
                        byte_done_nxt = !parity_bad;
`else
                        byte_done_nxt = 1'b1;
`endif
                    end else begin
                        frame_err_nxt = 1'b1;
                        state_nxt     = ST_BREAK;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_BREAK: begin
                // Wait out a held-low line so it reports a single error.
                if (rx_s) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Synchronizer, FSM registers and holding register.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_q1      <= 1'b1;
            rx_s       <= 1'b1;
            state      <= ST_IDLE;
            cnt        <= '0;
            idx        <= '0;
            shift      <= '0;
            byte_done  <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            data       <= 8'h00;
            data_valid <= 1'b0;
        end else begin
            rx_q1     <= rx;
            rx_s      <= rx_q1;
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            idx       <= idx_nxt;
            shift     <= shift_nxt;
            byte_done <= byte_done_nxt;
            frame_err <= frame_err_nxt;
            overrun   <= 1'b0;
            if (byte_done) begin
                // A same-cycle accept frees the register for the new byte.
                if (!data_valid || data_ready) begin
                    data       <= shift;
                    data_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity error pulse and per-frame discard flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            parity_err <= 1'b0;
            parity_bad <= 1'b0;
        end else begin
            parity_err <= parity_err_nxt;
            parity_bad <= parity_bad_nxt;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx at 16 clocks per bit.
// Table-driven frames, hand-written corner sequences and a randomized
// frame stream checked against a transaction-level expectation queue.
module tb_uart_rx;

    localparam int unsigned CPB = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic [7:0] data;
    logic       data_valid;
    logic       data_ready;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    int checks = 0;
    int errors = 0;

    // Monitor state: accepted bytes and pulse counts.
    logic [7:0] acc_q[$];
    int         ferr_cnt = 0;
    int         ovr_cnt  = 0;
    int         perr_cnt = 0;
    logic       prev_hold  = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    logic       prev_ferr  = 1'b0;

    typedef struct {
        logic [7:0] byte_in;
        logic       stop_bit;
        logic       pflip;
        int         n_exp;
        logic [7:0] data_exp;
        int         ferr_exp;
        int         perr_exp;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] exp_q[$];

    uart_rx #(
        .CLKS_PER_BIT(CPB),
        .CNT_W       (5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .data      (data),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Inputs change 2 time units after a rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic pflip,
                              input int extra_low, input int gap);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^b) ^ pflip;
        tick(CPB);
`else
        if (pflip) begin
            rx = 1'b1;
        end
`endif
        rx = stop_bit;
        tick(CPB);
        if (extra_low > 0) begin
            rx = 1'b0;
            tick(extra_low);
        end
        rx = 1'b1;
        tick(gap);
    endtask

    // Outputs sampled mid-cycle, when inputs are also stable.
    always @(negedge clk) begin
        if (data_valid && data_ready) begin
            acc_q.push_back(data);
        end
        if (frame_err) ferr_cnt++;
        if (overrun)   ovr_cnt++;
        if (parity_err) perr_cnt++;
        if (prev_hold && data_valid) begin
            check("data_stable", 32'(data), 32'(prev_data));
        end
        if (frame_err && prev_ferr) begin
            check("ferr_width", 32'(1), 32'(0));
        end
        prev_hold <= data_valid && !data_ready;
        prev_data <= data;
        prev_ferr <= frame_err;
    end

    initial begin
        int n0;
        int f0;
        int p0;
        int o0;
        logic [7:0] b;
        logic       stop_bit;
        logic       pflip;

        reset      = 1'b1;
        rx         = 1'b1;
        data_ready = 1'b1;
        tick(3);
        reset = 1'b0;
        @(negedge clk);
        check("rst_data", 32'(data), 32'h00);
        check("rst_valid", 32'(data_valid), 32'(0));
        check("rst_ferr", 32'(frame_err), 32'(0));
        check("rst_ovr", 32'(overrun), 32'(0));
        check("rst_perr", 32'(parity_err), 32'(0));
        tick(4);

        // Table of clean and faulty frames.
        vecs.push_back('{8'hA5, 1'b1, 1'b0, 1, 8'hA5, 0, 0});
        vecs.push_back('{8'h3C, 1'b1, 1'b0, 1, 8'h3C, 0, 0});
        vecs.push_back('{8'h00, 1'b1, 1'b0, 1, 8'h00, 0, 0});
        vecs.push_back('{8'hFF, 1'b1, 1'b0, 1, 8'hFF, 0, 0});
        vecs.push_back('{8'h7E, 1'b0, 1'b0, 0, 8'h00, 1, 0});
        vecs.push_back('{8'h81, 1'b1, 1'b0, 1, 8'h81, 0, 0});
`ifdef UART_RX_PARITY_EN
        vecs.push_back('{8'h03, 1'b1, 1'b1, 0, 8'h00, 0, 1});
        vecs.push_back('{8'h03, 1'b1, 1'b0, 1, 8'h03, 0, 0});
        vecs.push_back('{8'h55, 1'b0, 1'b1, 0, 8'h00, 1, 1});
`endif
        foreach (vecs[k]) begin
            n0 = acc_q.size();
            f0 = ferr_cnt;
            p0 = perr_cnt;
            o0 = ovr_cnt;
            send_frame(vecs[k].byte_in, vecs[k].stop_bit, vecs[k].pflip, 0, 6);
            check($sformatf("vec%0d_count", k), 32'(acc_q.size() - n0), 32'(vecs[k].n_exp));
            if (vecs[k].n_exp > 0 && acc_q.size() > n0) begin
                check($sformatf("vec%0d_data", k), 32'(acc_q[n0]), 32'(vecs[k].data_exp));
            end
            check($sformatf("vec%0d_ferr", k), 32'(ferr_cnt - f0), 32'(vecs[k].ferr_exp));
            check($sformatf("vec%0d_perr", k), 32'(perr_cnt - p0), 32'(vecs[k].perr_exp));
            check($sformatf("vec%0d_ovr", k), 32'(ovr_cnt - o0), 32'(0));
        end

        // Glitch shorter than half a bit, then a real frame.
        n0 = acc_q.size();
        f0 = ferr_cnt;
        rx = 1'b0;
        tick(5);
        rx = 1'b1;
        tick(40);
        check("glitch_count", 32'(acc_q.size() - n0), 32'(0));
        check("glitch_ferr", 32'(ferr_cnt - f0), 32'(0));
        send_frame(8'h3C, 1'b1, 1'b0, 0, 6);
        check("glitch_next_count", 32'(acc_q.size() - n0), 32'(1));
        if (acc_q.size() > n0) check("glitch_next_data", 32'(acc_q[n0]), 32'h3C);

        // Overrun: consumer stalled across two frames.
        n0 = acc_q.size();
        o0 = ovr_cnt;
        data_ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0, 0, 6);
        send_frame(8'h22, 1'b1, 1'b0, 0, 6);
        check("ovr_pulses", 32'(ovr_cnt - o0), 32'(1));
        check("ovr_valid", 32'(data_valid), 32'(1));
        check("ovr_held_data", 32'(data), 32'h11);
        data_ready = 1'b1;
        tick(1);
        data_ready = 1'b0;
        @(negedge clk);
        check("ovr_valid_cleared", 32'(data_valid), 32'(0));
        check("ovr_accepted", 32'(acc_q.size() - n0), 32'(1));
        if (acc_q.size() > n0) check("ovr_accepted_data", 32'(acc_q[n0]), 32'h11);
        data_ready = 1'b1;
        tick(4);

        // Bad stop bit followed by a long break.
        n0 = acc_q.size();
        f0 = ferr_cnt;
        send_frame(8'h7E, 1'b0, 1'b0, 40, 6);
        check("break_ferr", 32'(ferr_cnt - f0), 32'(1));
        check("break_count", 32'(acc_q.size() - n0), 32'(0));
        send_frame(8'h81, 1'b1, 1'b0, 0, 6);
        check("break_recover_count", 32'(acc_q.size() - n0), 32'(1));
        if (acc_q.size() > n0) check("break_recover_data", 32'(acc_q[n0]), 32'h81);

        // Reset during data bit 4 with a byte already held.
        data_ready = 1'b0;
        send_frame(8'h5A, 1'b1, 1'b0, 0, 6);
        check("pre_rst_valid", 32'(data_valid), 32'(1));
        check("pre_rst_data", 32'(data), 32'h5A);
        b  = 8'hF0;
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = b[4];
        tick(CPB / 2);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_data", 32'(data), 32'h00);
        check("midrst_valid", 32'(data_valid), 32'(0));
        check("midrst_ferr", 32'(frame_err), 32'(0));
        check("midrst_ovr", 32'(overrun), 32'(0));
        check("midrst_perr", 32'(parity_err), 32'(0));
        data_ready = 1'b1;
        n0 = acc_q.size();
        f0 = ferr_cnt;
        tick(CPB * 6);
        send_frame(8'hC3, 1'b1, 1'b0, 0, 6);
        check("midrst_next_count", 32'(acc_q.size() - n0), 32'(1));
        if (acc_q.size() > n0) check("midrst_next_data", 32'(acc_q[n0]), 32'hC3);
        check("midrst_next_ferr", 32'(ferr_cnt - f0), 32'(0));

        // Randomized frame stream against the expectation queue.
        acc_q.delete();
        f0 = ferr_cnt;
        p0 = perr_cnt;
        o0 = ovr_cnt;
        begin
            int exp_ferr = 0;
            int exp_perr = 0;
            for (int k = 0; k < 30; k++) begin
                b        = 8'($urandom_range(0, 255));
                stop_bit = ($urandom_range(0, 5) != 0);
`ifdef UART_RX_PARITY_EN
                pflip    = ($urandom_range(0, 4) == 0);
`else
                pflip    = 1'b0;
`endif
                if (pflip) exp_perr++;
                if (!stop_bit) exp_ferr++;
                if (!pflip && stop_bit) exp_q.push_back(b);
                send_frame(b, stop_bit, pflip, 0, $urandom_range(2, 20));
            end
            tick(8);
            check("rand_count", 32'(acc_q.size()), 32'(exp_q.size()));
            for (int k = 0; k < exp_q.size() && k < acc_q.size(); k++) begin
                check($sformatf("rand_byte%0d", k), 32'(acc_q[k]), 32'(exp_q[k]));
            end
            check("rand_ferr", 32'(ferr_cnt - f0), 32'(exp_ferr));
            check("rand_perr", 32'(perr_cnt - p0), 32'(exp_perr));
            check("rand_ovr", 32'(ovr_cnt - o0), 32'(0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver, the receive-side counterpart of the board's UART transmitter.
- Samples an asynchronous serial line from a PMOD pin in the 100 MHz `clk` domain.
- Recovers bytes LSB-first and presents them through a valid/ready holding register to downstream logic (LED display, command decoder).
- Reports framing errors and overruns as single-cycle pulses.

Parameters:
- CLKS_PER_BIT, 868, `clk` cycles per bit (100 MHz / 115200 baud); must be >= 4.
- CNT_W, 10, width of the bit-timing counter; must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- clk  input  1  system clock (100 MHz)
- reset  input  1  synchronous, active-high reset
- rx  input  1  asynchronous serial line; idle high
- data  output  8  received byte; valid while data_valid=1
- data_valid  output  1  holding register full
- data_ready  input  1  consumer accepts byte when data_valid & data_ready
- frame_err  output  1  one-cycle pulse: stop bit sampled low
- overrun  output  1  one-cycle pulse: byte completed while holding register still full; new byte dropped
- parity_err  output  1  one-cycle pulse: parity mismatch; constant 0 without the optional feature

Behaviour:
- Interface (decided): one clock `clk`; reset `reset` is synchronous and active-high.
- rx passes through a 2-flop synchronizer. Both flops reset to 1. All state decisions use the second flop (rx_s).
- Reset values:
  - data=8'h00, data_valid=0, frame_err=0, overrun=0, parity_err=0.
  - FSM=IDLE; counter=0; bit index=0.
- Reset mid-frame: abandons the frame and clears the holding register with no error pulse. Reception resumes on the next falling edge after reset deasserts.
- FSM states: IDLE, START, DATA, PARITY (feature only), STOP, BREAK.
- IDLE: when rx_s=0, go to START with counter cleared.
- START: count to CLKS_PER_BIT/2-1 (integer division) to reach mid-bit.
  - rx_s=1 there: false start, return to IDLE, no pulse.
  - rx_s=0: go to DATA with counter cleared.
- DATA: sample rx_s each time the counter reaches CLKS_PER_BIT-1, then clear the counter.
  - Shift the sample into bit[index], LSB first; index 0..7.
  - After bit 7, go to PARITY if enabled, else STOP.
- STOP: sample at CLKS_PER_BIT-1.
  - rx_s=1: byte complete, go to IDLE.
  - rx_s=0: frame_err pulse, byte discarded, go to BREAK.
- BREAK: wait for rx_s=1, then go to IDLE. A held-low line gives exactly one frame_err, not repeated frames.
- Byte complete, holding register:
  - data_valid=0, or data_valid=1 & data_ready=1 in the same cycle: load data and set data_valid=1 on the next edge.
  - Otherwise: overrun pulse; data and data_valid unchanged.
- Handshake:
  - data_valid & data_ready with no load in that cycle clears data_valid on the next edge.
  - data is stable while data_valid=1.
- Latency: data_valid rises 1 cycle after the stop-bit sample edge. That is about 9.5 bit times plus 3 cycles (synchronizer + load) after the rx falling edge.
- Error pulses are exactly 1 cycle wide and never coincide with a data_valid rising edge for the same frame.
- Counters wrap only by explicit clear; no free-running overflow.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - A PARITY state follows DATA and samples one extra bit at CLKS_PER_BIT-1.
  - Expected even parity: XOR of the 8 data bits equals the parity bit.
  - On mismatch: parity_err pulses 1 cycle, the byte is discarded (no load, no overrun check), and the FSM still proceeds to STOP. A bad stop bit still additionally pulses frame_err.
  - Frame is 8E1.
- Undefined: no PARITY state, parity_err tied to 0, frame is 8N1.

Test Plan (bench uses CLKS_PER_BIT=16, data_ready=1 unless stated):
- Send 8'hA5 8N1 at 16 clk/bit -> data_valid rises once with data=8'hA5; frame_err, overrun, parity_err stay 0.
- rx low for 5 clk, then high (glitch) -> no data_valid, no frame_err; the next frame 8'h3C is received correctly.
- data_ready=0; send 8'h11 then 8'h22 -> data=8'h11 held valid; one overrun pulse at the end of the second frame. After data_ready=1 for 1 cycle, data_valid=0.
- Send 8'h7E with stop bit 0, then rx held low for 40 clk -> exactly one frame_err pulse, no data_valid. Recovery: after rx returns high, 8'h81 is received correctly.
- Assert reset for 1 cycle at data bit 4 of a frame -> all outputs 0 the next cycle. The partial frame is ignored; the following frame 8'hC3 is received.
- With UART_RX_PARITY_EN: send 8'h03 with parity bit 1 -> parity_err pulse, no data_valid. Resend with parity bit 0 -> data=8'h03 valid.
